// File: rtl/axil_cmd_arbiter_pkg.sv
// Shared types and default parameter values for the AXI-Lite command arbiter.
//   arb_state_t : arbiter FSM states (idle, issue strobe, wait for driver, completion pulse)
//   *_DEF       : default values for NREQ, ADDR_W, DATA_W and TIMEOUT
package axil_arb_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_t;

endpackage

// File: rtl/axil_cmd_arbiter_if.sv
// Bundle of requester-side and driver-side command signals of the arbiter.
//   req_exec/req_we/req_addr/req_wdata : per-requester commands (slice i = requester i)
//   req_fin/req_err/req_rdata          : completion pulse, timeout flag, shared read data
//   m_exec/m_we/m_addr/m_wdata         : command strobe and latched command to the driver
//   m_rdata/m_fin                      : read data and completion pulse from the driver
// Modports: master = arbiter view, slave = requesters plus driver (environment) view.
interface axil_cmd_arbiter_if import axil_arb_pkg::*; #(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [NREQ-1:0]        req_exec;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_fin;
  logic                   req_err;
  logic [DATA_W-1:0]      req_rdata;

  logic                   m_exec;
  logic                   m_we;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic [DATA_W-1:0]      m_rdata;
  logic                   m_fin;

  modport master (
    input  req_exec, req_we, req_addr, req_wdata, m_rdata, m_fin,
    output req_fin, req_err, req_rdata, m_exec, m_we, m_addr, m_wdata
  );

  modport slave (
    output req_exec, req_we, req_addr, req_wdata, m_rdata, m_fin,
    input  req_fin, req_err, req_rdata, m_exec, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/axil_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   rr_ptr    : highest-priority index for this pick
//   mask      : requesters excluded from this pick
//   grant     : one-hot grant (all zero when nothing eligible)
//   grant_idx : index of the granted requester (0 when nothing eligible)
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] rr_ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant,
  output logic [IdxW-1:0] grant_idx
);

  logic            found;
  int              sum;
  logic [IdxW-1:0] pos;

  // Scan from rr_ptr upward, wrapping modulo NREQ; first eligible request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = 0;
    pos       = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= int'(NREQ)) sum = sum - int'(NREQ);
      pos = IdxW'(sum);
      if (!found && req[pos] && !mask[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/axil_cmd_arbiter.sv
// Round-robin arbiter serialising NREQ command requesters onto one AXI-Lite master driver.
//   clk    : clock, rising edge
//   nreset : asynchronous active-low reset
//   bus    : command interface (master modport): requester commands in, completion out,
//            command strobe and latched command to the driver, driver completion in
// A granted command is strobed once, then the arbiter waits for m_fin or a timeout of
// TIMEOUT cycles, and returns a one-cycle req_fin to the granted requester.
module axil_cmd_arbiter import axil_arb_pkg::*; #(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic                 clk,
  input logic                 nreset,
  axil_cmd_arbiter_if.master  bus
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   mask_q, mask_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0]   arb_grant;
  logic [IdxW-1:0]   arb_idx;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req       (bus.req_exec),
    .rr_ptr    (ptr_q),
    .mask      (mask_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // The mask only covers the single idle cycle following a completion.
        mask_d = '0;
        if (|arb_grant) begin
          grant_d = arb_idx;
          for (int i = 0; i < int'(NREQ); i++) begin
            if (arb_grant[i]) begin
              we_d    = bus.req_we[i];
              addr_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
              wdata_d = bus.req_wdata[i*DATA_W +: DATA_W];
            end
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.m_fin) begin
          rdata_d = we_q ? '0 : bus.m_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        ptr_d          = (grant_q == IdxW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        mask_d         = '0;
        mask_d[grant_q] = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched command is only visible while a transaction is in flight.
  always_comb begin
    bus.m_exec    = (state_q == StIssue);
    bus.m_we      = (state_q != StIdle) && we_q;
    bus.m_addr    = (state_q != StIdle) ? addr_q : '0;
    bus.m_wdata   = (state_q != StIdle) ? wdata_q : '0;
    bus.req_fin   = '0;
    if (state_q == StDone) bus.req_fin[grant_q] = 1'b1;
    bus.req_rdata = rdata_q;
    bus.req_err   = err_q;
  end

endmodule

// File: tb/tb_axil_cmd_arbiter.sv
module tb_axil_cmd_arbiter;
  import axil_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = TIMEOUT_DEF;

  logic clk = 1'b0;
  logic nreset = 1'b0;

  axil_cmd_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  axil_cmd_arbiter #(
    .NREQ    (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        exp_mwe;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_exec  = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.m_fin     = 1'b0;
    bus.m_rdata   = '0;
  endtask

  task automatic do_reset();
    #2 nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.req_exec[i]          = 1'b1;
    bus.req_we[i]            = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  // Returns number of cycles until m_exec is seen; bounded.
  task automatic wait_mexec(input string tag, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      cyc++;
      if (bus.m_exec) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s m_exec: got none, expected a strobe", tag);
    end
  endtask

  // Called in the m_exec cycle. lat = cycles from m_exec to m_fin; lat 0 = driver never answers.
  task automatic finish_txn(input string tag, input int lat, input logic [31:0] rdata,
                            input int idx, input logic [31:0] exp_rd, input logic exp_err,
                            input bit drop);
    logic [N-1:0] exp_fin;
    int cnt;
    bit seen;
    exp_fin = '0;
    exp_fin[idx] = 1'b1;
    tick();
    check({tag, " m_exec single"}, bus.m_exec, 1'b0);
    if (lat > 0) begin
      repeat (lat - 1) tick();
      bus.m_fin   = 1'b1;
      bus.m_rdata = rdata;
      tick();
      bus.m_fin   = 1'b0;
      bus.m_rdata = ~rdata;
    end else begin
      bus.m_rdata = rdata;
      seen = 1'b0;
      cnt  = 0;
      while (!seen && cnt < 200) begin
        tick();
        cnt++;
        if (bus.req_fin != '0) seen = 1'b1;
      end
      check({tag, " timeout cycles"}, cnt, TO);
    end
    check({tag, " req_fin"}, bus.req_fin, exp_fin);
    check({tag, " req_rdata"}, bus.req_rdata, exp_rd);
    check({tag, " req_err"}, bus.req_err, exp_err);
    if (drop) bus.req_exec[idx] = 1'b0;
    tick();
    check({tag, " req_fin single"}, bus.req_fin, '0);
  endtask

  // Reference model state for the randomized phase.
  logic [N-1:0] live, prev_live, exp_fin_r;
  int           blk [N];
  bit           hold [N];
  logic         cmd_we [N];
  logic [31:0]  cmd_addr [N];
  logic [31:0]  cmd_wdata [N];
  int           ptr, g, lat, mfin_t, fin_t;
  bit           in_txn, busy_prev, this_busy, is_to, exp_mexec;
  logic [31:0]  exp_rd, rd;
  logic         exp_err;

  function automatic int pick(input logic [N-1:0] lv, input int p);
    for (int k = 0; k < N; k++) begin
      if (lv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial begin
    int cyc;
    int pulses;
    logic any;

    vecs[0] = '{2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3,
                1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{0, 1'b1, 32'h1000, 32'hCAFE0001, 32'h12345678, 1,
                1'b1, 32'h1000, 32'hCAFE0001, 32'h0, 1'b0};
    vecs[2] = '{3, 1'b0, 32'hFFFFFFFC, 32'h55, 32'hA5A5A5A5, 5,
                1'b0, 32'hFFFFFFFC, 32'h55, 32'hA5A5A5A5, 1'b0};
    vecs[3] = '{1, 1'b0, 32'h4, 32'h0, 32'h0BADF00D, 2,
                1'b0, 32'h4, 32'h0, 32'h0BADF00D, 1'b0};
    vecs[4] = '{1, 1'b1, 32'h8, 32'hFFFFFFFF, 32'h11111111, 7,
                1'b1, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[5] = '{3, 1'b0, 32'h20, 32'h0, 32'h77777777, 1,
                1'b0, 32'h20, 32'h0, 32'h77777777, 1'b0};

    drive_idle();
    #3;
    check("reset ctl", {bus.req_fin, bus.req_err, bus.m_exec, bus.m_we}, '0);
    check("reset addr/wdata", {bus.m_addr, bus.m_wdata}, '0);
    check("reset rdata", bus.req_rdata, '0);
    tick();
    tick();
    nreset = 1'b1;

    // Single transactions from the table.
    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      set_req(vecs[k].idx, vecs[k].we, vecs[k].addr, vecs[k].wdata);
      wait_mexec(tag, cyc);
      check({tag, " latency"}, cyc, 1);
      check({tag, " m_cmd"}, {bus.m_we, bus.m_addr, bus.m_wdata},
            {vecs[k].exp_mwe, vecs[k].exp_maddr, vecs[k].exp_mwdata});
      finish_txn(tag, vecs[k].lat, vecs[k].rdata, vecs[k].idx,
                 vecs[k].exp_rdata, vecs[k].exp_err, 1'b1);
      tick();
    end

    // Timeout: the driver never answers; read data forced to 0, err set.
    set_req(0, 1'b0, 32'h40, 32'h0);
    wait_mexec("timeout", cyc);
    finish_txn("timeout", 0, 32'h99999999, 0, 32'h0, 1'b1, 1'b1);
    tick();

    // All four write at once from reset: served 0,1,2,3.
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 32'(k * 256), 32'hA0000000 + 32'(k));
    pulses = 0;
    for (int k = 0; k < N; k++) begin
      string tag;
      tag = $sformatf("all4 #%0d", k);
      wait_mexec(tag, cyc);
      if (bus.m_exec) pulses++;
      check({tag, " grant"}, {bus.m_we, bus.m_addr, bus.m_wdata},
            {1'b1, 32'(k * 256), 32'hA0000000 + 32'(k)});
      finish_txn(tag, 2, 32'h55555555, k, 32'h0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.m_exec) pulses++;
    end
    check("all4 m_exec count", pulses, 4);

    // Fairness: 1 and 3 held continuously alternate, no back-to-back regrant.
    set_req(1, 1'b0, 32'h1001, 32'h0);
    set_req(3, 1'b0, 32'h1003, 32'h0);
    for (int k = 0; k < 8; k++) begin
      string tag;
      int exp_g;
      exp_g = (k % 2 == 0) ? 1 : 3;
      tag = $sformatf("fair #%0d", k);
      wait_mexec(tag, cyc);
      check({tag, " latency"}, cyc, 1);
      check({tag, " grant addr"}, bus.m_addr, 32'h1000 + 32'(exp_g));
      finish_txn(tag, 1, 32'h2000 + 32'(k), exp_g, 32'h2000 + 32'(k), 1'b0, 1'b0);
    end
    bus.req_exec = '0;
    tick();

    // Spurious m_fin while idle is ignored.
    bus.m_fin   = 1'b1;
    bus.m_rdata = 32'hFFFF0000;
    tick();
    bus.m_fin = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      any = any | (|bus.req_fin) | bus.m_exec;
      tick();
    end
    check("spurious no activity", any, 1'b0);
    check("spurious rdata held", bus.req_rdata, 32'h2007);
    set_req(0, 1'b1, 32'h50, 32'h5);
    wait_mexec("post-spurious", cyc);
    check("post-spurious latency", cyc, 1);
    finish_txn("post-spurious", 2, 32'h0, 0, 32'h0, 1'b0, 1'b1);
    tick();

    // Reset during WAIT: silent abort, then normal operation.
    set_req(2, 1'b0, 32'h300, 32'h1234);
    wait_mexec("rst-wait", cyc);
    tick();
    tick();
    #2 nreset = 1'b0;
    #1;
    check("rst-wait ctl", {bus.req_fin, bus.req_err, bus.m_exec, bus.m_we}, '0);
    check("rst-wait addr/wdata", {bus.m_addr, bus.m_wdata}, '0);
    bus.req_exec = '0;
    tick();
    tick();
    nreset = 1'b1;
    bus.m_fin = 1'b1;
    tick();
    bus.m_fin = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 6; k++) begin
      any = any | (|bus.req_fin) | bus.m_exec;
      tick();
    end
    check("rst-wait no fin/reissue", any, 1'b0);
    set_req(1, 1'b0, 32'h400, 32'h0);
    wait_mexec("post-rst", cyc);
    check("post-rst latency", cyc, 1);
    check("post-rst addr", bus.m_addr, 32'h400);
    finish_txn("post-rst", 2, 32'h600D, 1, 32'h600D, 1'b0, 1'b1);

    // Randomized traffic against a transaction-level model.
    drive_idle();
    do_reset();
    live = '0;
    prev_live = '0;
    ptr = 0;
    in_txn = 1'b0;
    busy_prev = 1'b0;
    g = 0; fin_t = -1; mfin_t = -1; is_to = 1'b0;
    exp_rd = '0; exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      blk[i] = 0; hold[i] = 1'b0; cmd_we[i] = 1'b0; cmd_addr[i] = '0; cmd_wdata[i] = '0;
    end
    for (int t = 0; t < 1500; t++) begin
      tick();
      exp_mexec = !busy_prev && (prev_live != '0);
      check("rnd m_exec", bus.m_exec, exp_mexec);
      this_busy = in_txn;
      if (exp_mexec) begin
        g = pick(prev_live, ptr);
        in_txn = 1'b1;
        this_busy = 1'b1;
        is_to = ($urandom_range(0, 15) == 0);
        lat = $urandom_range(1, 6);
        mfin_t = t + lat;
        fin_t = is_to ? t + 1 + TO : t + lat + 1;
        exp_rd = '0;
        exp_err = is_to;
      end
      if (this_busy)
        check("rnd m_cmd", {bus.m_we, bus.m_addr, bus.m_wdata},
              {cmd_we[g], cmd_addr[g], cmd_wdata[g]});
      else
        check("rnd m_cmd idle", {bus.m_we, bus.m_addr, bus.m_wdata}, '0);
      exp_fin_r = '0;
      if (in_txn && t == fin_t) exp_fin_r[g] = 1'b1;
      check("rnd req_fin", bus.req_fin, exp_fin_r);
      if (exp_fin_r != '0) begin
        check("rnd req_rdata", bus.req_rdata, exp_rd);
        check("rnd req_err", bus.req_err, exp_err);
        ptr = (g + 1) % N;
        live[g] = 1'b0;
        blk[g] = 2;
        hold[g] = 1'($urandom_range(0, 1));
        in_txn = 1'b0;
      end
      // Drive the next cycle's inputs.
      bus.m_fin = 1'b0;
      if (in_txn && !is_to && t == mfin_t) begin
        rd = $urandom;
        bus.m_fin = 1'b1;
        bus.m_rdata = rd;
        exp_rd = cmd_we[g] ? 32'h0 : rd;
      end else begin
        bus.m_rdata = $urandom;
        if (!this_busy && $urandom_range(0, 7) == 0) bus.m_fin = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (blk[i] == 2) begin
          blk[i] = 1;
        end else if (blk[i] == 1) begin
          blk[i] = 0;
          bus.req_exec[i] = hold[i];
        end else if (!live[i]) begin
          bus.req_exec[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            live[i] = 1'b1;
            cmd_we[i] = 1'($urandom_range(0, 1));
            cmd_addr[i] = $urandom;
            cmd_wdata[i] = $urandom;
            set_req(i, cmd_we[i], cmd_addr[i], cmd_wdata[i]);
          end
        end
      end
      prev_live = live;
      busy_prev = this_busy;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
